// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store requests into single-beat bus accesses.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses skip the bus and finish with err.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUout,
    input  logic [31:0] RegOp2,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_load, is_store, access, misaligned, timeout_hit;
    logic [1:0]  size;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;

    // A simultaneous read and write request is treated as a load.
    assign is_load  = MemRead;
    assign is_store = MemWrite & ~MemRead;
    assign access   = MemRead | MemWrite;
    assign mem_addr = {ALUout[31:2], 2'b00};
    assign ReadData = rdata_q;
    assign timeout_hit = (cnt_q + 8'd1) == 8'(TIMEOUT);

    // size: 0 byte, 1 halfword, 2 word (reserved encodings fall into word)
    always_comb begin
        size = 2'd2;
        if (funct3[1:0] == 2'b00)      size = 2'd0;
        else if (funct3[1:0] == 2'b01) size = 2'd1;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((size == 2'd1) && ALUout[0]) ||
                        ((size == 2'd2) && (ALUout[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (ALUout[1:0])
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            2'd3:    byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = ALUout[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size)
            2'd0:    load_fmt = {{24{~funct3[2] & byte_sel[7]}}, byte_sel};
            2'd1:    load_fmt = {{16{~funct3[2] & half_sel[15]}}, half_sel};
            default: load_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        case (size)
            2'd0: begin
                be_calc    = 4'b0001 << ALUout[1:0];
                wdata_calc = {4{RegOp2[7:0]}};
            end
            2'd1: begin
                be_calc    = 4'b0011 << {ALUout[1], 1'b0};
                wdata_calc = {2{RegOp2[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = RegOp2;
            end
        endcase
        if (is_load) be_calc = 4'b1111;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = 32'd0;
        stall     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    stall = 1'b1;
                    cnt_d = 8'd0;
                    err_d = 1'b0;
                    if (misaligned) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        if (is_load) rdata_d = 32'd0;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = is_store;
                mem_be    = be_calc;
                mem_wdata = wdata_calc;
                cnt_d     = cnt_q + 8'd1;
                // An expiring budget wins over a grant arriving in the same cycle.
                if (timeout_hit) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else if (mem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (mem_rvalid) begin
                    state_d = S_DONE;
                    if (is_load) rdata_d = load_fmt;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
